regmap_arbiter: RTL
===================

Name: regmap_arbiter

Overview:
- Two-requester round-robin arbiter and access sequencer for the 2-register control map (reg0 2-bit, reg1 1-bit).
- Accepts read/write requests on two independent valid/ready ports and serialises them onto the map's single WRITE/READ/ADDR/WRITE_DATA/READ_DATA port.
- Returns read data and a completion pulse to the owning requester.
- Sits between the host bus bridge (requester 0), the debug/scan port (requester 1) and the register map.

Parameters:
- ADDR_W, 3, address width for requesters and map.
- DATA_W, 2, data width for requesters and map.
- NUM_REGS, 2, number of implemented map addresses (0..NUM_REGS-1).

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST_N  input  1  asynchronous active-low reset.
- REQ0_VALID  input  1  requester 0 has a request pending.
- REQ0_WRITE  input  1  1 = write, 0 = read.
- REQ0_ADDR  input  ADDR_W  request address.
- REQ0_WDATA  input  DATA_W  write data.
- REQ0_READY  output  1  request accepted this cycle.
- REQ0_DONE  output  1  one-cycle completion pulse.
- REQ0_RDATA  output  DATA_W  read data, valid when REQ0_DONE=1.
- REQ1_VALID, REQ1_WRITE, REQ1_ADDR, REQ1_WDATA, REQ1_READY, REQ1_DONE, REQ1_RDATA: same as requester 0.
- RM_WRITE  output  1  map write strobe.
- RM_READ  output  1  map read strobe.
- RM_ADDR  output  ADDR_W  map address.
- RM_WDATA  output  DATA_W  map write data.
- RM_RDATA  input  DATA_W  map combinational read data.
- REQ_ERR  output  1  only with ARB_ADDR_CHECK_EN; valid with DONE.

Behaviour:
- Reset (RST_N=0, immediate, async): FSM=IDLE, all outputs 0, captured request regs 0, LAST_GNT=1 so requester 0 wins first.
- FSM IDLE: if any VALID, select winner, assert winner's READY (combinational, IDLE only), capture WRITE/ADDR/WDATA/id on the edge, go to ACCESS. Else stay IDLE.
- Arbitration: one VALID wins alone. Both VALID: grant the requester not equal to LAST_GNT. LAST_GNT updates on every grant.
- FSM ACCESS (1 cycle): RM_ADDR/RM_WDATA driven from captured regs. RM_WRITE=1 for writes; RM_READ=1 for reads. RM_RDATA is sampled into RDATA reg at end of cycle (reads only). Next state is DONE.
- FSM DONE (1 cycle): owner's DONE=1 and owner's RDATA=captured data. RDATA is 0 for writes. Other requester's DONE=0. Next state is IDLE.
- RM_* outputs are 0 outside ACCESS. REQn_RDATA holds its last value until the next DONE for that requester.
- Latency: VALID high at edge N (IDLE) -> RM strobe cycle N+1 -> DONE cycle N+2. Max throughput: one access per 3 cycles.
- Requesters hold VALID and fields stable until READY. Fields may change after acceptance without effect.
- VALID dropped before READY: request withdrawn, no access.
- VALID held high after READY is a new request and is arbitrated again in the next IDLE.
- Reset mid-ACCESS: strobes drop asynchronously, no map write occurs, no DONE is issued, and the requester must re-issue.
- Width: addresses and data pass through unmodified, with no truncation or extension inside the block.

Optional Feature:
- ARB_ADDR_CHECK_EN defined:
  - A captured ADDR >= NUM_REGS skips the map access: ACCESS keeps RM_WRITE/RM_READ=0.
  - DONE pulses with REQ_ERR=1 and RDATA=0. REQ_ERR=0 for valid addresses.
  - Latency is unchanged.
- Undefined:
  - REQ_ERR port is absent.
  - All addresses are forwarded; out-of-range reads return whatever the map drives (held value).

Test Plan:
- Reset, REQ0 write ADDR=0 WDATA=2'b10 -> RM_WRITE=1 with RM_ADDR=0, RM_WDATA=2 in cycle N+1; REQ0_DONE in N+2. Then REQ0 read ADDR=0 -> REQ0_RDATA=2'b10 with DONE.
- REQ0 and REQ1 both VALID from reset, both reads ADDR=1 -> REQ0 granted first, REQ1 READY in the next IDLE (cycle N+3). DONEs in N+2 and N+5.
- Both requesters stream 4 requests each continuously -> grants strictly alternate 0,1,0,1...; each requester gets exactly 4 DONEs.
- REQ1 write ADDR=1 WDATA=1, assert RST_N=0 during ACCESS -> RM_WRITE drops immediately, reg1 unchanged (read back 0), no REQ1_DONE.
- With ARB_ADDR_CHECK_EN: REQ0 read ADDR=5 -> no RM_READ/RM_WRITE; REQ0_DONE=1, REQ_ERR=1, REQ0_RDATA=0 at N+2. ADDR=1 read -> REQ_ERR=0.
- REQ0 VALID asserted while FSM in ACCESS for REQ1 -> REQ0_READY stays 0 until IDLE, then granted.

Source files
------------

// File: rtl/regmap_arbiter.sv
// Two-requester round-robin arbiter that serialises accesses onto the 2-register control map.
// Optional macro ARB_ADDR_CHECK_EN: out-of-range addresses skip the map and complete with req_err_o.
module regmap_arbiter #(
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned DATA_W   = 2,
  parameter int unsigned NUM_REGS = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req0_valid_i,
  input  logic              req0_write_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [DATA_W-1:0] req0_wdata_i,
  output logic              req0_ready_o,
  output logic              req0_done_o,
  output logic [DATA_W-1:0] req0_rdata_o,
  input  logic              req1_valid_i,
  input  logic              req1_write_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [DATA_W-1:0] req1_wdata_i,
  output logic              req1_ready_o,
  output logic              req1_done_o,
  output logic [DATA_W-1:0] req1_rdata_o,
  output logic              rm_write_o,
  output logic              rm_read_o,
  output logic [ADDR_W-1:0] rm_addr_o,
  output logic [DATA_W-1:0] rm_wdata_o,
`ifdef ARB_ADDR_CHECK_EN
  output logic              req_err_o,
`endif
  input  logic [DATA_W-1:0] rm_rdata_i
);

`ifdef ARB_ADDR_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_e;

  state_e            state_q;
  logic              last_gnt_q;
  logic              cap_id_q;
  logic              cap_write_q;
  logic              cap_bad_q;

  logic              any_valid_c;
  logic              sel_id_c;
  logic              sel_write_c;
  logic              sel_bad_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [DATA_W-1:0] sel_wdata_c;
  logic [DATA_W-1:0] rdata_c;

  // A lone requester wins; under contention the one not granted last time wins.
  always_comb begin
    any_valid_c = req0_valid_i | req1_valid_i;
    sel_id_c    = (req0_valid_i && req1_valid_i) ? ~last_gnt_q : req1_valid_i;
    sel_write_c = sel_id_c ? req1_write_i : req0_write_i;
    sel_addr_c  = sel_id_c ? req1_addr_i  : req0_addr_i;
    sel_wdata_c = sel_id_c ? req1_wdata_i : req0_wdata_i;
    sel_bad_c   = CheckEn && (sel_addr_c >= ADDR_W'(NUM_REGS));
    rdata_c     = (cap_write_q || cap_bad_q) ? '0 : rm_rdata_i;
  end

  assign req0_ready_o = (state_q == ST_IDLE) && any_valid_c && !sel_id_c;
  assign req1_ready_o = (state_q == ST_IDLE) && any_valid_c &&  sel_id_c;

  // Sequencer: IDLE (grant) -> ACCESS (map strobe) -> DONE (completion pulse).
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      last_gnt_q   <= 1'b1;
      cap_id_q     <= 1'b0;
      cap_write_q  <= 1'b0;
      cap_bad_q    <= 1'b0;
      rm_write_o   <= 1'b0;
      rm_read_o    <= 1'b0;
      rm_addr_o    <= '0;
      rm_wdata_o   <= '0;
      req0_done_o  <= 1'b0;
      req1_done_o  <= 1'b0;
      req0_rdata_o <= '0;
      req1_rdata_o <= '0;
`ifdef ARB_ADDR_CHECK_EN
      req_err_o    <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_valid_c) begin
            state_q     <= ST_ACCESS;
            last_gnt_q  <= sel_id_c;
            cap_id_q    <= sel_id_c;
            cap_write_q <= sel_write_c;
            cap_bad_q   <= sel_bad_c;
            rm_write_o  <= sel_write_c && !sel_bad_c;
            rm_read_o   <= !sel_write_c && !sel_bad_c;
            rm_addr_o   <= sel_addr_c;
            rm_wdata_o  <= sel_wdata_c;
          end
        end
        ST_ACCESS: begin
          state_q    <= ST_DONE;
          rm_write_o <= 1'b0;
          rm_read_o  <= 1'b0;
          rm_addr_o  <= '0;
          rm_wdata_o <= '0;
          if (cap_id_q) begin
            req1_done_o  <= 1'b1;
            req1_rdata_o <= rdata_c;
          end else begin
            req0_done_o  <= 1'b1;
            req0_rdata_o <= rdata_c;
          end
`ifdef ARB_ADDR_CHECK_EN
          req_err_o <= cap_bad_q;
`endif
        end
        ST_DONE: begin
          state_q     <= ST_IDLE;
          req0_done_o <= 1'b0;
          req1_done_o <= 1'b0;
`ifdef ARB_ADDR_CHECK_EN
          req_err_o   <= 1'b0;
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
